fpd_iter: RTL and testbench
===========================

Name: fpd_iter

Overview:
- Iterative IEEE-754 single-precision floating-point divider, computing c = a / b. It is the inverse-direction companion to the pipelined multiplier.
- It uses a restoring radix-2 mantissa divider controlled by a small FSM.
- A valid/ready handshake on the input and on the output lets it sit beside the multiplier in the arithmetic datapath.
- Denormal inputs are flushed to zero.

Parameters:
- BIAS, 127: exponent bias.
- QBITS, 26: number of quotient bits produced. This is 24 mantissa bits plus 1 normalisation bit plus 1 guard bit. Values below 26 are illegal.
- CANON_NAN, 32'h7FC00000: the NaN pattern emitted for every NaN result.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands.
- a  in  32  dividend, IEEE-754 single.
- b  in  32  divisor, IEEE-754 single.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- c  out  32  quotient, IEEE-754 single.
- flags  out  4  {invalid, div_zero, overflow, underflow}; valid while out_valid.

Behaviour:
- Reset (rst=0, async):
  - State goes to IDLE.
  - c=0, flags=0, out_valid=0, in_ready=1.
  - Any operation in flight is discarded.
- in_ready = (state==IDLE). Operands are accepted on a rising edge where in_valid && in_ready.
- Classification at acceptance (exponent field 0 counts as zero):
  - NaN operand, 0/0, or inf/inf: c=CANON_NAN, invalid=1.
  - finite/0 (nonzero dividend): c=signed inf, div_zero=1.
  - inf/finite: c=signed inf.
  - 0/nonzero, or finite/inf: c=signed zero.
  - For all of the above, go directly to DONE. out_valid is high in the cycle after acceptance (latency 1).
- Normal path, IDLE -> DIV:
  - Latch sign = sa^sb.
  - Exponent: 10-bit signed e = ea - eb + BIAS.
  - rem = {1,ma}, div = {1,mb}, iteration counter = 0.
- DIV, one quotient bit per cycle, QBITS cycles:
  - q bit = (rem >= div); on a 1, rem -= div.
  - Then rem <<= 1. The quotient shifts in MSB first.
- NORM, one cycle:
  - If q[25]=1: mantissa = q[25:2], guard = q[1], sticky = q[0] | (rem != 0).
  - Otherwise: mantissa = q[24:1], guard = q[0], sticky = (rem != 0), and e -= 1.
  - Round according to ROUND_NEAREST_EN (see Optional Feature).
  - If rounding carries out of the mantissa: mantissa = 1.0 and e += 1.
  - If e >= 255: c = signed inf, overflow=1.
  - If e <= 0: c = signed zero, underflow=1.
  - Otherwise: c = {sign, e[7:0], mantissa[22:0]}.
- DONE:
  - Normal latency: out_valid rises 27 edges after the acceptance edge.
  - out_valid, c and flags stay stable until out_valid && out_ready. On that handshake, go to IDLE and drop out_valid.
  - in_ready returns the next cycle; there is no same-cycle re-accept.
- in_valid while busy is ignored; the operands are not latched.
- Reset in any state aborts the operation immediately.

Optional Feature:
- ROUND_NEAREST_EN defined: round to nearest, ties to even. Increment the mantissa when guard && (sticky || mantissa[0]).
- ROUND_NEAREST_EN undefined: truncate, ignoring guard and sticky. Latency is identical in both builds.

Decomposition:
- Package fp_pkg holds:
  - constants EXP_W=8, MAN_W=23, BIAS, INF_POS=32'h7F800000, CANON_NAN;
  - the FSM state enum {IDLE, DIV, NORM, DONE};
  - flag bit indices.
- One sub-module, fp_classify (combinational), decodes an operand pair into zero/inf/nan/sign flags. It is reusable by the multiplier.

Test Plan:
- 8.0/2.0: a=0x41000000, b=0x40000000 -> c=0x40800000, flags=0, out_valid 27 cycles after accept.
- 1/3: a=0x3F800000, b=0x40400000 -> c=0x3EAAAAAB with ROUND_NEAREST_EN, 0x3EAAAAAA without.
- Special cases (each latency 1):
  - 1/0 -> 0x7F800000, div_zero.
  - 0/0 -> 0x7FC00000, invalid.
  - -0/5.0 (0x80000000 / 0x40A00000) -> 0x80000000.
- Overflow/underflow:
  - 0x7F000000 / 0x3E800000 -> 0x7F800000, overflow.
  - 0x00800000 / 0x40000000 -> 0x00000000, underflow.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> c and flags stable, in_ready=0 throughout. Release -> in_ready=1 the next cycle.
- Reset mid-DIV: assert rst=0 at iteration 10 -> out_valid=0 and c=0 at once. After release, in_ready=1, and a fresh 8/2 completes correctly.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared constants, FSM encoding and operand-class type for the single-precision
// arithmetic blocks (divider, multiplier).
package fp_pkg;

  localparam int unsigned EXP_W     = 8;
  localparam int unsigned MAN_W     = 23;
  localparam int unsigned BIAS      = 127;
  localparam logic [31:0] INF_POS   = 32'h7F80_0000;
  localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

  // FSM encoding, kept as plain constants so older tools can share it.
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t DIV  = 2'd1;
  localparam state_t NORM = 2'd2;
  localparam state_t DONE = 2'd3;

  // Bit positions inside the 4-bit flags vector.
  localparam int unsigned FLAG_INVALID   = 3;
  localparam int unsigned FLAG_DIV_ZERO  = 2;
  localparam int unsigned FLAG_OVERFLOW  = 1;
  localparam int unsigned FLAG_UNDERFLOW = 0;

  typedef struct packed {
    logic sign;
    logic zero;
    logic inf;
    logic nan;
  } fp_class_t;

endpackage

// File: rtl/fp_classify.sv
// Combinational operand-pair decoder: sign/zero/inf/nan per operand.
// A zero exponent field counts as zero, so denormals are flushed.
module fp_classify
  import fp_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output fp_class_t   a_cls_o,
  output fp_class_t   b_cls_o
);

  logic [EXP_W-1:0] a_exp;
  logic [EXP_W-1:0] b_exp;
  logic [MAN_W-1:0] a_man;
  logic [MAN_W-1:0] b_man;

  assign a_exp = a_i[MAN_W+EXP_W-1:MAN_W];
  assign b_exp = b_i[MAN_W+EXP_W-1:MAN_W];
  assign a_man = a_i[MAN_W-1:0];
  assign b_man = b_i[MAN_W-1:0];

  always_comb begin
    a_cls_o.sign = a_i[31];
    a_cls_o.zero = (a_exp == '0);
    a_cls_o.inf  = (a_exp == '1) && (a_man == '0);
    a_cls_o.nan  = (a_exp == '1) && (a_man != '0);

    b_cls_o.sign = b_i[31];
    b_cls_o.zero = (b_exp == '0);
    b_cls_o.inf  = (b_exp == '1) && (b_man == '0);
    b_cls_o.nan  = (b_exp == '1) && (b_man != '0);
  end

endmodule

// File: rtl/fpd_iter.sv
// Iterative single-precision divider c = a / b with a restoring radix-2 mantissa core.
// Define ROUND_NEAREST_EN for round-to-nearest-even; otherwise the result is truncated.
module fpd_iter #(
  parameter int unsigned BIAS      = 127,
  parameter int unsigned QBITS     = 26,  // must be >= 26
  parameter logic [31:0] CANON_NAN = 32'h7FC0_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] c,
  output logic [3:0]  flags
);

  import fp_pkg::*;

  localparam int unsigned CNT_W = $clog2(QBITS);

  state_t            state_q, state_d;
  logic [24:0]       rem_q, rem_d;
  logic [23:0]       div_q, div_d;
  logic [QBITS-1:0]  quo_q, quo_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic signed [9:0] exp_q, exp_d;
  logic              sign_q, sign_d;
  logic [31:0]       c_q, c_d;
  logic [3:0]        flags_q, flags_d;

  fp_class_t a_cls;
  fp_class_t b_cls;

  fp_classify u_classify (
    .a_i     (a),
    .b_i     (b),
    .a_cls_o (a_cls),
    .b_cls_o (b_cls)
  );

  // Special-operand decode, used only on the acceptance cycle.
  logic        res_sign;
  logic        spec_hit;
  logic [31:0] spec_c;
  logic [3:0]  spec_flags;

  assign res_sign = a_cls.sign ^ b_cls.sign;

  always_comb begin
    spec_hit   = 1'b1;
    spec_c     = '0;
    spec_flags = '0;
    if (a_cls.nan || b_cls.nan || (a_cls.zero && b_cls.zero) || (a_cls.inf && b_cls.inf)) begin
      spec_c                   = CANON_NAN;
      spec_flags[FLAG_INVALID] = 1'b1;
    end else if (a_cls.inf) begin
      spec_c = {res_sign, INF_POS[30:0]};
    end else if (b_cls.zero) begin
      spec_c                    = {res_sign, INF_POS[30:0]};
      spec_flags[FLAG_DIV_ZERO] = 1'b1;
    end else if (a_cls.zero || b_cls.inf) begin
      spec_c = {res_sign, 31'd0};
    end else begin
      spec_hit = 1'b0;
    end
  end

  // One restoring step. The partial remainder stays below 2*div, so 25 bits suffice
  // and the post-subtract value always fits in 24 bits before the shift.
  logic [24:0] div_ext;
  logic        q_bit;
  logic [23:0] rem_sub;

  assign div_ext = {1'b0, div_q};
  assign q_bit   = (rem_q >= div_ext);
  assign rem_sub = q_bit ? 24'(rem_q - div_ext) : rem_q[23:0];

  // Normalisation and rounding on the finished quotient.
  logic [25:0] q_top;
  logic        low_sticky;
  logic        rem_nz;

  assign q_top  = quo_q[QBITS-1 -: 26];
  assign rem_nz = |rem_q;

  if (QBITS > 26) begin : g_low_sticky
    assign low_sticky = |quo_q[QBITS-27:0];
  end else begin : g_no_low_sticky
    assign low_sticky = 1'b0;
  end

  logic [22:0]       frac_n;
  logic              guard;
  logic              sticky;
  logic              round_up;
  logic [23:0]       frac_rnd;
  logic signed [9:0] exp_n;
  logic signed [9:0] exp_f;
  logic [22:0]       frac_f;
  logic [31:0]       norm_c;
  logic [3:0]        norm_flags;

  always_comb begin
    frac_n     = '0;
    guard      = 1'b0;
    sticky     = 1'b0;
    exp_n      = exp_q;
    round_up   = 1'b0;
    frac_rnd   = '0;
    exp_f      = exp_q;
    frac_f     = '0;
    norm_c     = '0;
    norm_flags = '0;

    // Leading one is either q_top[25] or, failing that, q_top[24]; it is the hidden bit.
    if (q_top[25]) begin
      frac_n = q_top[24:2];
      guard  = q_top[1];
      sticky = q_top[0] | rem_nz | low_sticky;
    end else begin
      frac_n = q_top[23:1];
      guard  = q_top[0];
      sticky = rem_nz | low_sticky;
      exp_n  = exp_q - 10'sd1;
    end

`ifdef ROUND_NEAREST_EN
    round_up = guard & (sticky | frac_n[0]);
`else
    round_up = guard & sticky & 1'b0;
`endif

    frac_rnd = {1'b0, frac_n} + {23'd0, round_up};
    if (frac_rnd[23]) begin
      frac_f = '0;
      exp_f  = exp_n + 10'sd1;
    end else begin
      frac_f = frac_rnd[22:0];
      exp_f  = exp_n;
    end

    if (exp_f >= 10'sd255) begin
      norm_c                    = {sign_q, INF_POS[30:0]};
      norm_flags[FLAG_OVERFLOW] = 1'b1;
    end else if (exp_f <= 10'sd0) begin
      norm_c                     = {sign_q, 31'd0};
      norm_flags[FLAG_UNDERFLOW] = 1'b1;
    end else begin
      norm_c = {sign_q, exp_f[7:0], frac_f};
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    div_d   = div_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    exp_d   = exp_q;
    sign_d  = sign_q;
    c_d     = c_q;
    flags_d = flags_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (spec_hit) begin
            c_d     = spec_c;
            flags_d = spec_flags;
            state_d = DONE;
          end else begin
            sign_d  = res_sign;
            exp_d   = $signed({2'b00, a[30:23]} - {2'b00, b[30:23]} + 10'(BIAS));
            rem_d   = {2'b01, a[22:0]};
            div_d   = {1'b1, b[22:0]};
            quo_d   = '0;
            cnt_d   = '0;
            state_d = DIV;
          end
        end
      end
      DIV: begin
        rem_d = {rem_sub, 1'b0};
        quo_d = {quo_q[QBITS-2:0], q_bit};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(QBITS - 1)) begin
          state_d = NORM;
        end
      end
      NORM: begin
        c_d     = norm_c;
        flags_d = norm_flags;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      div_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      exp_q   <= '0;
      sign_q  <= 1'b0;
      c_q     <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      div_q   <= div_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      exp_q   <= exp_d;
      sign_q  <= sign_d;
      c_q     <= c_d;
      flags_q <= flags_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign c         = c_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_fpd_iter.sv
// Bench for fpd_iter: directed plan cases, then random operands against an
// arithmetic reference quotient. Honours ROUND_NEAREST_EN like the design.
module tb_fpd_iter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] c;
  logic [3:0]  flags;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fpd_iter dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .c         (c),
    .flags     (flags)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: quotient of the two 24-bit significands scaled by 2^25, then IEEE rules.
  function automatic void ref_div(input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] rc, output logic [3:0] rf,
                                  output bit special);
    bit s, zx, zy, ix, iy, nx, ny, g, st, rne;
    int ex, ey, e;
    longint unsigned ma, mb, num, q, r, man;
    s  = x[31] ^ y[31];
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    zx = (ex == 0);
    zy = (ey == 0);
    ix = (ex == 255) && (x[22:0] == 23'd0);
    iy = (ey == 255) && (y[22:0] == 23'd0);
    nx = (ex == 255) && (x[22:0] != 23'd0);
    ny = (ey == 255) && (y[22:0] != 23'd0);
    special = 1'b1;
    rf = 4'b0000;
    rc = 32'd0;
    if (nx || ny || (zx && zy) || (ix && iy)) begin
      rc = 32'h7FC00000; rf = 4'b1000; return;
    end
    if (ix) begin rc = {s, 31'h7F800000}; return; end
    if (zy) begin rc = {s, 31'h7F800000}; rf = 4'b0100; return; end
    if (zx || iy) begin rc = {s, 31'd0}; return; end
    special = 1'b0;
    ma  = 64'(x[22:0]) | (64'd1 << 23);
    mb  = 64'(y[22:0]) | (64'd1 << 23);
    num = ma << 25;
    q   = num / mb;
    r   = num % mb;
    e   = ex - ey + 127;
    if (q >= (64'd1 << 25)) begin
      man = q >> 2; g = q[1]; st = q[0] || (r != 0);
    end else begin
      man = q >> 1; g = q[0]; st = (r != 0); e = e - 1;
    end
`ifdef ROUND_NEAREST_EN
    rne = 1'b1;
`else
    rne = 1'b0;
`endif
    if (rne && g && (st || man[0])) man = man + 1;
    if (man == (64'd1 << 24)) begin man = 64'd1 << 23; e = e + 1; end
    if (e >= 255) begin
      rc = {s, 31'h7F800000}; rf = 4'b0010;
    end else if (e <= 0) begin
      rc = {s, 31'd0}; rf = 4'b0001;
    end else begin
      rc = {s, 8'(e), man[22:0]};
    end
  endfunction

  // Full transaction: accept, wait for result, optional backpressure, handshake.
  task automatic do_op(input string tag, input logic [31:0] ta, input logic [31:0] tb_,
                       input logic [31:0] ec, input logic [3:0] ef, input int elat,
                       input int hold, input bit poke);
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
    check({tag, "/in_ready_idle"}, {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; a = ta; b = tb_;
    @(posedge clk); #1;
    in_valid = poke;
    if (poke) begin a = $urandom; b = $urandom; end
    n = 0;
    while (out_valid !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
    in_valid = 1'b0;
    check({tag, "/latency"}, 32'(n), 32'(elat));
    check({tag, "/c"}, c, ec);
    check({tag, "/flags"}, {28'd0, flags}, {28'd0, ef});
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, "/hold_valid"}, {31'd0, out_valid}, 32'd1);
      check({tag, "/hold_c"}, c, ec);
      check({tag, "/hold_flags"}, {28'd0, flags}, {28'd0, ef});
      check({tag, "/hold_in_ready"}, {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "/valid_drop"}, {31'd0, out_valid}, 32'd0);
    check({tag, "/in_ready_back"}, {31'd0, in_ready}, 32'd1);
  endtask

  function automatic logic [31:0] rand_operand();
    logic [31:0] v;
    int sel;
    v   = $urandom;
    sel = int'($urandom_range(0, 15));
    case (sel)
      0:       v[30:0] = 31'd0;
      1:       v[30:0] = 31'h7F800000;
      2:       begin v[30:23] = 8'hFF; v[0] = 1'b1; end
      3:       begin v[30:23] = 8'h00; v[5] = 1'b1; end
      default: v[30:23] = 8'($urandom_range(1, 254));
    endcase
    return v;
  endfunction

  initial begin
    logic [31:0] ra, rb, rc;
    logic [3:0]  rf;
    bit          sp;

    // Reset state while rst is held low.
    #1;
    check("reset/out_valid", {31'd0, out_valid}, 32'd0);
    check("reset/in_ready", {31'd0, in_ready}, 32'd1);
    check("reset/c", c, 32'd0);
    check("reset/flags", {28'd0, flags}, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    do_op("div_8_2", 32'h41000000, 32'h40000000, 32'h40800000, 4'b0000, 27, 0, 1'b0);
`ifdef ROUND_NEAREST_EN
    do_op("div_1_3", 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0000, 27, 0, 1'b0);
`else
    do_op("div_1_3", 32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 4'b0000, 27, 0, 1'b0);
`endif
    do_op("one_by_zero", 32'h3F800000, 32'h00000000, 32'h7F800000, 4'b0100, 0, 0, 1'b0);
    do_op("zero_by_zero", 32'h00000000, 32'h00000000, 32'h7FC00000, 4'b1000, 0, 0, 1'b0);
    do_op("negzero_by_5", 32'h80000000, 32'h40A00000, 32'h80000000, 4'b0000, 0, 0, 1'b0);
    do_op("overflow", 32'h7F000000, 32'h3E800000, 32'h7F800000, 4'b0010, 27, 0, 1'b0);
    do_op("underflow", 32'h00800000, 32'h40000000, 32'h00000000, 4'b0001, 27, 0, 1'b0);
    do_op("backpressure", 32'h41000000, 32'h40000000, 32'h40800000, 4'b0000, 27, 5, 1'b1);

    // Abort in the middle of the mantissa iterations.
    in_valid = 1'b1; a = 32'h41000000; b = 32'h40000000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("abort/out_valid", {31'd0, out_valid}, 32'd0);
    check("abort/c", c, 32'd0);
    check("abort/flags", {28'd0, flags}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort/in_ready", {31'd0, in_ready}, 32'd1);
    do_op("after_abort", 32'h41000000, 32'h40000000, 32'h40800000, 4'b0000, 27, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      ra = rand_operand();
      rb = rand_operand();
      ref_div(ra, rb, rc, rf, sp);
      do_op($sformatf("rand%0d_%h_%h", i, ra, rb), ra, rb, rc, rf, sp ? 0 : 27,
            int'($urandom_range(0, 2)), 1'(i % 2));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
